simple_dp_ram: RTL

//   Parametrised single-clock two-port RAM for the debug fabric: one write port, one read port.
//   - Write port has per-byte enables; read port is pipelined with a valid flag.
//   - After reset the block clears its contents by itself.
//   - Used as a scratch/trace buffer between the EBI bridge and the debug capture logic.

---
 rtl/simple_dp_ram_if.sv | 38 +++
 rtl/simple_dp_ram.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/simple_dp_ram_if.sv
// -----------------------------------------------------------------------------
// simple_dp_ram_if
// Purpose : bundles the write port, read port and status of simple_dp_ram so
//           the RAM and its user share one typed connection.
// Signals : wr_i / wr_addr_i / wr_data_i / wr_be_i   write request, byte lanes
//           rd_i / rd_addr_i                          read request
//           rd_data_o / rd_valid_o                    pipelined read return
//           busy_o                                    post-reset clear running
// Modports: master - the RAM user (drives requests, receives data)
//           slave  - the RAM itself
// -----------------------------------------------------------------------------
interface simple_dp_ram_if #(
    parameter int LOG2_SIZE  = 5,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_i;
    logic [LOG2_SIZE-1:0]  wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [NBYTES-1:0]     wr_be_i;
    logic                  rd_i;
    logic [LOG2_SIZE-1:0]  rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  busy_o;

    modport master (
        output wr_i, wr_addr_i, wr_data_i, wr_be_i, rd_i, rd_addr_i,
        input  rd_data_o, rd_valid_o, busy_o
    );

    modport slave (
        input  wr_i, wr_addr_i, wr_data_i, wr_be_i, rd_i, rd_addr_i,
        output rd_data_o, rd_valid_o, busy_o
    );
endinterface

// File: rtl/simple_dp_ram.sv
// -----------------------------------------------------------------------------
// simple_dp_ram
// Purpose : single-clock RAM with one byte-enabled write port and one
//           pipelined read port (latency 1 or 2) with a valid flag. After
//           reset it sweeps CLEAR_VALUE into every word, reporting busy_o and
//           ignoring requests until the sweep is done.
// Ports   : clk_i      rising-edge clock
//           reset_n_i  asynchronous active-low reset
//           bus        simple_dp_ram_if.slave (requests, read return, busy_o)
// Config  : SIMPLE_DP_RAM_BYPASS_EN
//             defined   - a read colliding with a same-edge write returns the
//                         merged (written) data, write-through
//             undefined - a colliding read returns the old contents
// Notes   : READ_LATENCY other than 2 builds the latency-1 pipeline.
// -----------------------------------------------------------------------------
module simple_dp_ram #(
    parameter int                    LOG2_SIZE    = 5,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    simple_dp_ram_if.slave  bus
);
    localparam int SIZE   = 2 ** LOG2_SIZE;
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [LOG2_SIZE-1:0]  ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] storage_q [SIZE];
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] rd_raw_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // FSM next state: sweep the clear pointer, then stay in RUN until reset
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + LOG2_SIZE'(1);
                if (ptr_q == {LOG2_SIZE{1'b1}}) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = {LOG2_SIZE{1'b0}};
                busy_d  = 1'b1;
            end
        endcase
    end

    // FSM state, clear pointer and busy flag registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= {LOG2_SIZE{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Requests only count once the clear sweep has finished
    always_comb begin
        wr_en_s = (state_q == ST_RUN) && bus.wr_i;
        rd_en_s = (state_q == ST_RUN) && bus.rd_i;
    end

    // Storage: clear sweep, then per-lane writes. No reset here on purpose:
    // the sweep itself initialises every word after each reset.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            storage_q[ptr_q] <= CLEAR_VALUE;
        end else if (wr_en_s) begin
            for (int n = 0; n < NBYTES; n++) begin
                if (bus.wr_be_i[n]) begin
                    storage_q[bus.wr_addr_i][n*BYTE_WIDTH +: BYTE_WIDTH] <=
                        bus.wr_data_i[n*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

`ifdef SIMPLE_DP_RAM_BYPASS_EN
    logic [DATA_WIDTH-1:0] rd_merged_s;
    logic                  rd_hit_s;

    // Write-through: colliding read sees enabled lanes from the write data
    always_comb begin
        rd_raw_s    = storage_q[bus.rd_addr_i];
        rd_hit_s    = wr_en_s && (bus.wr_addr_i == bus.rd_addr_i);
        rd_merged_s = rd_raw_s;
        for (int n = 0; n < NBYTES; n++) begin
            rd_merged_s[n*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_be_i[n] ?
                bus.wr_data_i[n*BYTE_WIDTH +: BYTE_WIDTH] :
                rd_raw_s[n*BYTE_WIDTH +: BYTE_WIDTH];
        end
        rd_word_s = rd_hit_s ? rd_merged_s : rd_raw_s;
    end
`else
    // Read-first: a colliding read sees the contents before the write
    always_comb begin
        rd_raw_s  = storage_q[bus.rd_addr_i];
        rd_word_s = rd_raw_s;
    end
`endif

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  pipe_valid_q;
            logic [DATA_WIDTH-1:0] pipe_data_q;

            // Two-stage read return; data and valid travel together
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    pipe_valid_q <= 1'b0;
                    pipe_data_q  <= {DATA_WIDTH{1'b0}};
                    rd_valid_q   <= 1'b0;
                    rd_data_q    <= {DATA_WIDTH{1'b0}};
                end else begin
                    pipe_valid_q <= rd_en_s;
                    pipe_data_q  <= rd_en_s ? rd_word_s : pipe_data_q;
                    rd_valid_q   <= pipe_valid_q;
                    rd_data_q    <= pipe_valid_q ? pipe_data_q : rd_data_q;
                end
            end
        end else begin : g_lat1
            // Single-stage read return; data holds between reads
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= {DATA_WIDTH{1'b0}};
                end else begin
                    rd_valid_q <= rd_en_s;
                    rd_data_q  <= rd_en_s ? rd_word_s : rd_data_q;
                end
            end
        end
    endgenerate

    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.busy_o     = busy_q;

endmodule
